// File: rtl/runahead_commit_event_gen.sv
// Purpose: buffers PCs committed during a runahead episode and emits them as
//          ordered event records to a difftest sink.
// Latency: a commit pushed at edge N appears on io_ev_valid after edge N
//          (registered, no bypass).
// Backpressure: io_ev_ready low holds the head record stable. A commit that
//          arrives when the FIFO is full and nothing pops is dropped, and the
//          sticky io_overflow flag is set.
// Ports:
//   clock, reset              sole clock; asynchronous active-high reset
//   io_coreid                 hart id, passed through to io_ev_coreid
//   io_runahead_enter/exit    one-cycle episode start/end pulses
//   io_commit_valid/pc        committed instruction and its PC
//   io_ev_ready               sink accepts the head event this cycle
//   io_ev_valid/coreid/index/pc  head event record
//   io_busy                   episode active or still draining
//   io_overflow               at least one commit dropped this episode
module runahead_commit_event_gen #(
   parameter int DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  io_coreid,
   input  logic        io_runahead_enter,
   input  logic        io_runahead_exit,
   input  logic        io_commit_valid,
   input  logic [63:0] io_commit_pc,
   input  logic        io_ev_ready,
   output logic        io_ev_valid,
   output logic [7:0]  io_ev_coreid,
   output logic [7:0]  io_ev_index,
   output logic [63:0] io_ev_pc,
   output logic        io_busy,
   output logic        io_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [63:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [AW:0]     w_count_nxt;
   logic [7:0]      r_index;
   logic            r_overflow;

   logic            w_enter_acc;
   logic            w_push_req;
   logic            w_ev_vld;
   logic            w_pop;
   logic            w_full;
   logic            w_push;
   logic            w_drop;

   // Enter only counts in IDLE; the enter cycle itself already belongs to the
   // episode, so its commit is captured.
   assign w_enter_acc = (r_state == S_IDLE) && io_runahead_enter;
   assign w_push_req  = io_commit_valid && ((r_state == S_RUN) || w_enter_acc);
   assign w_ev_vld    = (r_count != '0);
   assign w_pop       = w_ev_vld && io_ev_ready;
   assign w_full      = (r_count == C_DEPTH);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push      = w_push_req && (!w_full || w_pop);
   assign w_drop      = w_push_req && !w_push;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (io_runahead_enter) w_state_nxt = S_RUN;
         S_RUN:   if (io_runahead_exit)  w_state_nxt = S_DRAIN;
         // Leave DRAIN on the same edge that empties the FIFO.
         S_DRAIN: if (w_count_nxt == '0) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_index    <= 8'd0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_enter_acc)  r_index <= 8'd0;
         else if (w_pop)   r_index <= r_index + 8'd1;
         if (w_enter_acc)  r_overflow <= 1'b0;
         else if (w_drop)  r_overflow <= 1'b1;
      end
   end

   // Storage needs no reset: an empty count masks whatever it holds.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= io_commit_pc;
   end

   assign io_ev_valid  = w_ev_vld;
   assign io_ev_coreid = io_coreid;
   assign io_ev_index  = r_index;
   assign io_ev_pc     = w_ev_vld ? r_mem[r_rd_ptr] : 64'd0;
   assign io_busy      = (r_state != S_IDLE);
   assign io_overflow  = r_overflow;

endmodule

// File: tb/tb_runahead_commit_event_gen.sv
module tb_runahead_commit_event_gen;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  io_coreid;
   logic        io_runahead_enter;
   logic        io_runahead_exit;
   logic        io_commit_valid;
   logic [63:0] io_commit_pc;
   logic        io_ev_ready;
   logic        io_ev_valid;
   logic [7:0]  io_ev_coreid;
   logic [7:0]  io_ev_index;
   logic [63:0] io_ev_pc;
   logic        io_busy;
   logic        io_overflow;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   runahead_commit_event_gen #(.DEPTH(8)) dut (
      .clock(clock), .reset(reset), .io_coreid(io_coreid),
      .io_runahead_enter(io_runahead_enter), .io_runahead_exit(io_runahead_exit),
      .io_commit_valid(io_commit_valid), .io_commit_pc(io_commit_pc),
      .io_ev_ready(io_ev_ready), .io_ev_valid(io_ev_valid),
      .io_ev_coreid(io_ev_coreid), .io_ev_index(io_ev_index),
      .io_ev_pc(io_ev_pc), .io_busy(io_busy), .io_overflow(io_overflow)
   );

   typedef struct {
      logic        en;
      logic        ex;
      logic        cv;
      logic [63:0] pc;
      logic        rdy;
      logic        e_vld;
      logic [7:0]  e_idx;
      logic [63:0] e_pc;
      logic        e_busy;
      logic        e_ovf;
   } vec_t;

   vec_t vt [18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic en, input logic ex, input logic cv,
                        input logic [63:0] pc, input logic rdy);
      io_runahead_enter = en;
      io_runahead_exit  = ex;
      io_commit_valid   = cv;
      io_commit_pc      = pc;
      io_ev_ready       = rdy;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 64'd0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pops;
      logic [63:0] exp_q [$];
      io_coreid = 8'h5A;
      do_reset();

      // reset state
      chk("rst_valid", 64'(io_ev_valid), 64'd0);
      chk("rst_busy",  64'(io_busy), 64'd0);
      chk("rst_ovf",   64'(io_overflow), 64'd0);
      chk("rst_index", 64'(io_ev_index), 64'd0);
      chk("rst_pc",    io_ev_pc, 64'd0);
      chk("coreid",    64'(io_ev_coreid), 64'h5A);

      // Expected outputs are those seen during the cycle the inputs are applied.
      //          en ex cv  pc            rdy  vld idx  e_pc          busy ovf
      vt[0]  = '{0, 0, 0, 64'h0,        1,   0, 8'd0, 64'h0,        0, 0};
      vt[1]  = '{1, 1, 1, 64'h80000000, 1,   0, 8'd0, 64'h0,        0, 0};
      vt[2]  = '{0, 0, 1, 64'h80000004, 1,   1, 8'd0, 64'h80000000, 1, 0};
      vt[3]  = '{0, 0, 1, 64'h80000008, 1,   1, 8'd1, 64'h80000004, 1, 0};
      vt[4]  = '{0, 0, 0, 64'h0,        1,   1, 8'd2, 64'h80000008, 1, 0};
      vt[5]  = '{1, 0, 0, 64'h0,        1,   0, 8'd3, 64'h0,        1, 0};
      vt[6]  = '{0, 0, 0, 64'h0,        1,   0, 8'd3, 64'h0,        1, 0};
      vt[7]  = '{0, 1, 1, 64'h10,       0,   0, 8'd3, 64'h0,        1, 0};
      vt[8]  = '{0, 0, 1, 64'h14,       0,   1, 8'd3, 64'h10,       1, 0};
      vt[9]  = '{0, 0, 0, 64'h0,        0,   1, 8'd3, 64'h10,       1, 0};
      vt[10] = '{0, 0, 0, 64'h0,        1,   1, 8'd3, 64'h10,       1, 0};
      vt[11] = '{0, 0, 0, 64'h0,        1,   0, 8'd4, 64'h0,        0, 0};
      vt[12] = '{0, 0, 1, 64'h20,       1,   0, 8'd4, 64'h0,        0, 0};
      vt[13] = '{0, 0, 0, 64'h0,        1,   0, 8'd4, 64'h0,        0, 0};
      vt[14] = '{1, 0, 0, 64'h0,        1,   0, 8'd4, 64'h0,        0, 0};
      vt[15] = '{0, 1, 0, 64'h0,        1,   0, 8'd0, 64'h0,        1, 0};
      vt[16] = '{0, 0, 0, 64'h0,        1,   0, 8'd0, 64'h0,        1, 0};
      vt[17] = '{0, 0, 0, 64'h0,        1,   0, 8'd0, 64'h0,        0, 0};

      for (int i = 0; i < 18; i++) begin
         drive(vt[i].en, vt[i].ex, vt[i].cv, vt[i].pc, vt[i].rdy);
         #1;
         chk($sformatf("vec%0d_valid", i), 64'(io_ev_valid), 64'(vt[i].e_vld));
         chk($sformatf("vec%0d_index", i), 64'(io_ev_index), 64'(vt[i].e_idx));
         chk($sformatf("vec%0d_busy", i),  64'(io_busy), 64'(vt[i].e_busy));
         chk($sformatf("vec%0d_ovf", i),   64'(io_overflow), 64'(vt[i].e_ovf));
         if (vt[i].e_vld) chk($sformatf("vec%0d_pc", i), io_ev_pc, vt[i].e_pc);
         step();
      end

      // Overflow: 9 commits into 8 entries, then push-at-full-with-pop.
      do_reset();
      drive(1, 0, 0, 64'd0, 0);
      step();
      for (int i = 0; i < 9; i++) begin
         drive(0, 0, 1, 64'h1000 + 64'(4*i), 0);
         step();
      end
      drive(0, 0, 0, 64'd0, 0);
      #1;
      chk("ovf_valid", 64'(io_ev_valid), 64'd1);
      chk("ovf_flag",  64'(io_overflow), 64'd1);
      for (int i = 0; i < 8; i++) exp_q.push_back(64'h1000 + 64'(4*i));
      exp_q.push_back(64'h2000);
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, (k == 0), 64'h2000, 1);
         #1;
         chk($sformatf("ovf_pop%0d_valid", k), 64'(io_ev_valid), 64'd1);
         chk($sformatf("ovf_pop%0d_pc", k), io_ev_pc, exp_q[k]);
         chk($sformatf("ovf_pop%0d_index", k), 64'(io_ev_index), 64'(k));
         step();
      end
      chk("ovf_empty", 64'(io_ev_valid), 64'd0);
      chk("ovf_sticky", 64'(io_overflow), 64'd1);
      drive(0, 1, 0, 64'd0, 1);
      step();
      drive(0, 0, 0, 64'd0, 1);
      step();
      chk("ovf_idle", 64'(io_busy), 64'd0);
      drive(1, 0, 0, 64'd0, 1);
      step();
      chk("ovf_cleared_on_enter", 64'(io_overflow), 64'd0);

      // 300 commits streaming: index wraps 255 -> 0.
      do_reset();
      drive(1, 0, 0, 64'd0, 1);
      step();
      pops = 0;
      for (int c = 0; c < 320 && pops < 300; c++) begin
         drive(0, 0, (c < 300), 64'(c) * 64'd4, 1);
         #1;
         if (io_ev_valid) begin
            chk($sformatf("wrap%0d_index", pops), 64'(io_ev_index), 64'(pops % 256));
            chk($sformatf("wrap%0d_pc", pops), io_ev_pc, 64'(pops) * 64'd4);
            pops++;
         end
         step();
      end
      chk("wrap_pops", 64'(pops), 64'd300);
      chk("wrap_final_index", 64'(io_ev_index), 64'd44);

      // Drain with 4 buffered and ready toggling; DRAIN commits discarded.
      do_reset();
      drive(1, 0, 0, 64'd0, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 64'h3000 + 64'(4*i), 0);
         step();
      end
      drive(0, 1, 0, 64'd0, 0);
      step();
      pops = 0;
      for (int c = 0; c < 20 && pops < 4; c++) begin
         drive(0, 0, 1, 64'hDEAD0000 + 64'(c), c[0]);
         #1;
         chk($sformatf("drain_c%0d_busy", c), 64'(io_busy), 64'd1);
         if (io_ev_valid && io_ev_ready) begin
            chk($sformatf("drain_pop%0d_pc", pops), io_ev_pc, 64'h3000 + 64'(4*pops));
            pops++;
         end
         step();
      end
      chk("drain_pops", 64'(pops), 64'd4);
      drive(0, 0, 0, 64'd0, 1);
      #1;
      chk("drain_idle_busy", 64'(io_busy), 64'd0);
      chk("drain_idle_valid", 64'(io_ev_valid), 64'd0);
      step();
      chk("drain_no_extra", 64'(io_ev_valid), 64'd0);

      // Asynchronous reset with 5 buffered.
      do_reset();
      drive(1, 0, 0, 64'd0, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1, 64'h4000 + 64'(4*i), 0);
         step();
      end
      drive(0, 0, 0, 64'd0, 0);
      chk("arst_pre_valid", 64'(io_ev_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", 64'(io_ev_valid), 64'd0);
      chk("arst_busy",  64'(io_busy), 64'd0);
      chk("arst_pc",    io_ev_pc, 64'd0);
      #1 reset = 1'b0;
      pops = 0;
      for (int c = 0; c < 10; c++) begin
         drive(0, 1, 1, 64'h5000, 1);
         #1;
         if (io_ev_valid || io_busy) pops++;
         step();
      end
      chk("arst_nothing_after", 64'(pops), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/runahead_commit_event_gen.md
RUNAHEAD_COMMIT_EVENT_GEN -- requirements
Module: runahead_commit_event_gen

Interface
REQ-001 Parameter: DEPTH, 8, event FIFO entries (power of two, 2..64).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 io_coreid  input  8  hart id, forwarded unmodified on io_ev_coreid.
REQ-005 io_runahead_enter  input  1  one-cycle pulse: core enters runahead.
REQ-006 io_runahead_exit  input  1  one-cycle pulse: core leaves runahead.
REQ-007 io_commit_valid  input  1  one instruction committed this cycle.
REQ-008 io_commit_pc  input  64  PC of the committed instruction.
REQ-009 io_ev_ready  input  1  downstream difftest sink accepts an event this cycle.
REQ-010 io_ev_valid  output  1  event record present.
REQ-011 io_ev_coreid  output  8  copy of io_coreid.
REQ-012 io_ev_index  output  8  per-episode event sequence number.
REQ-013 io_ev_pc  output  64  PC of the event record.
REQ-014 io_busy  output  1  state is not IDLE.
REQ-015 io_overflow  output  1  sticky: at least one commit dropped this episode.

Function
REQ-016 FSM states IDLE, RUN, DRAIN; reset state IDLE.
REQ-017 IDLE -> RUN on io_runahead_enter; io_runahead_exit ignored in IDLE, including when simultaneous with enter.
REQ-018 RUN -> DRAIN on io_runahead_exit; io_runahead_enter ignored in RUN and DRAIN.
REQ-019 DRAIN -> IDLE in the cycle FIFO count becomes 0 (immediately next cycle if already empty at exit).
REQ-020 Push condition: io_commit_valid and (state==RUN, or state==IDLE with io_runahead_enter asserted); commits in the exit cycle are pushed; commits in IDLE otherwise and in DRAIN are discarded.
REQ-021 Push accepted iff count<DEPTH, or count==DEPTH and a pop occurs in the same cycle; otherwise commit dropped and io_overflow set next cycle.
REQ-022 Pop when io_ev_valid and io_ev_ready; io_ev_valid = (count!=0), combinational from FIFO state only.
REQ-023 io_ev_pc = PC at FIFO head; FIFO order strictly preserved; pointers wrap modulo DEPTH.
REQ-024 Latency: commit pushed at edge N is visible on io_ev_valid after edge N; no same-cycle bypass.
REQ-025 io_ev_index = 8-bit pop counter, incremented per pop, wraps 255->0; reset to 0 and io_overflow cleared on each accepted enter.
REQ-026 io_ev_pc/io_ev_index hold stable while io_ev_valid and not io_ev_ready.
REQ-027 io_busy = (state!=IDLE).
REQ-028 Simultaneous push and pop at any count leaves count unchanged.

Reset
REQ-029 On reset: state IDLE, count 0, pointers 0, index 0, io_overflow 0, io_ev_valid 0, io_busy 0; io_ev_pc reads 0.
REQ-030 Reset mid-RUN or mid-DRAIN discards all buffered events; no event emitted after reset until a new enter.

Verification
REQ-031 Enter, 3 commits PC 0x80000000/04/08, ready=1 -> events index 0,1,2 with same PCs, one per cycle starting cycle after first commit.
REQ-032 ready=0, 9 commits in RUN with DEPTH=8 -> count 8, io_overflow=1, 9th PC absent; ready=1 -> 8 events in order.
REQ-033 300 commits with ready=1 -> index sequence 0..255,0..43; wrap correct.
REQ-034 Exit with 4 buffered, ready toggling -> busy stays 1 until 4th pop, IDLE next cycle; commits during DRAIN not emitted.
REQ-035 enter+exit same cycle in IDLE -> state RUN; second enter in RUN -> index not reset.
REQ-036 Async reset asserted with 5 buffered -> io_ev_valid 0 immediately, io_busy 0, nothing emitted afterwards.
